// File: rtl/llr_addr_gen.sv
`default_nettype none
// ============================================================================
// Module      : llr_addr_gen
// Description : LLR RAM / intrinsic-info RAM address generator for the LDPC
//               decoder. It follows the controller's phase strobes
//               (initialise / CPU / VPU) and produces registered read and
//               write addresses. In the CPU loop, the circulant shift of the
//               current base-matrix entry is applied modulo DEPTH.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, rst_n        : clock, asynchronous active-low reset
//   initial_on        : initialise phase active
//   cpu_on / vpu_on   : CPU / VPU phase active
//   llr_ram_rden      : LLR read strobe (advances read counter)
//   in_info_rden      : intrinsic-RAM read strobe (advances info counter)
//   vpu_wr_addr_en    : VPU write-back strobe
//   cpu_wr_addr_en    : CPU write-back strobe
//   shift_val         : circulant shift, captured on the cpu_on rising edge
//   llr_rd_addr       : LLR RAM read address (registered)
//   llr_wr_addr       : LLR RAM write address (registered)
//   llr_wr_vld        : llr_wr_addr valid this cycle
//   in_info_rd_addr   : intrinsic RAM read address (registered)
//   rd_wrap           : one-cycle pulse after the read counter wraps
//   wr_done           : one-cycle pulse after the write counter wraps
//   phase_err         : sticky protocol-error flag
// ============================================================================
module llr_addr_gen #(
    parameter int ADDR_WIDTH = 8,
    parameter int DEPTH      = 256,
    parameter int RW_DELAY   = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  initial_on,
    input  logic                  cpu_on,
    input  logic                  vpu_on,
    input  logic                  llr_ram_rden,
    input  logic                  in_info_rden,
    input  logic                  vpu_wr_addr_en,
    input  logic                  cpu_wr_addr_en,
    input  logic [ADDR_WIDTH-1:0] shift_val,
    output logic [ADDR_WIDTH-1:0] llr_rd_addr,
    output logic [ADDR_WIDTH-1:0] llr_wr_addr,
    output logic                  llr_wr_vld,
    output logic [ADDR_WIDTH-1:0] in_info_rd_addr,
    output logic                  rd_wrap,
    output logic                  wr_done,
    output logic                  phase_err
);

    localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] MAX_CNT   = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH-1:0] ONE       = ADDR_WIDTH'(1);

    // Counter increment with wrap at DEPTH-1 (DEPTH need not be a power of 2).
    function automatic logic [ADDR_WIDTH-1:0] wrap_inc(input logic [ADDR_WIDTH-1:0] v);
        return (v == MAX_CNT) ? '0 : v + ONE;
    endfunction

    // (a + b) mod DEPTH for a, b < DEPTH: one conditional subtraction suffices.
    function automatic logic [ADDR_WIDTH-1:0] mod_add(input logic [ADDR_WIDTH-1:0] a,
                                                      input logic [ADDR_WIDTH-1:0] b);
        logic [ADDR_WIDTH:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum >= DEPTH_EXT) begin
            sum = sum - DEPTH_EXT;
        end
        return sum[ADDR_WIDTH-1:0];
    endfunction

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic                                 initial_on_q, cpu_on_q, vpu_on_q;
    logic [ADDR_WIDTH-1:0]                shift_q,           shift_d;
    logic [ADDR_WIDTH-1:0]                rd_cnt_q,          rd_cnt_d;
    logic [ADDR_WIDTH-1:0]                wr_cnt_q,          wr_cnt_d;
    logic [ADDR_WIDTH-1:0]                info_cnt_q,        info_cnt_d;
    logic [ADDR_WIDTH-1:0]                llr_rd_addr_q,     llr_rd_addr_d;
    logic [ADDR_WIDTH-1:0]                llr_wr_addr_q,     llr_wr_addr_d;
    logic                                 llr_wr_vld_q,      llr_wr_vld_d;
    logic [ADDR_WIDTH-1:0]                in_info_rd_addr_q, in_info_rd_addr_d;
    logic                                 rd_wrap_q,         rd_wrap_d;
    logic                                 wr_done_q,         wr_done_d;
    logic                                 phase_err_q,       phase_err_d;
    logic [RW_DELAY-1:0][ADDR_WIDTH-1:0]  pipe_addr_q,       pipe_addr_d;
    logic [RW_DELAY-1:0]                  pipe_vld_q,        pipe_vld_d;

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic                  init_rise, cpu_rise, vpu_rise, any_rise;
    logic                  shift_bad, wr_strobe, drain_vld, collide, multi_on;
    logic [ADDR_WIDTH-1:0] shift_load, shift_eff;
    logic [ADDR_WIDTH-1:0] rd_eff, wr_eff, info_eff;

    always_comb begin
        init_rise = initial_on & ~initial_on_q;
        cpu_rise  = cpu_on     & ~cpu_on_q;
        vpu_rise  = vpu_on     & ~vpu_on_q;
        any_rise  = init_rise | cpu_rise | vpu_rise;

        // On a phase-start cycle the counters are treated as already cleared,
        // so a strobe in that same cycle uses address 0 and leaves count 1.
        rd_eff    = any_rise ? '0 : rd_cnt_q;
        wr_eff    = any_rise ? '0 : wr_cnt_q;
        info_eff  = any_rise ? '0 : info_cnt_q;

        // The freshly captured shift is used in the CPU start cycle itself.
        shift_bad  = cpu_rise && ({1'b0, shift_val} >= DEPTH_EXT);
        shift_load = shift_bad ? '0 : shift_val;
        shift_eff  = cpu_rise ? shift_load : shift_q;
        shift_d    = shift_eff;

        // Read side
        rd_cnt_d  = llr_ram_rden ? wrap_inc(rd_eff) : rd_eff;
        rd_wrap_d = llr_ram_rden && (rd_eff == MAX_CNT);
        llr_rd_addr_d = llr_rd_addr_q;
        if (cpu_on) begin
            llr_rd_addr_d = mod_add(rd_eff, shift_eff);
        end else if (vpu_on) begin
            llr_rd_addr_d = rd_eff;
        end

        // Intrinsic-info side
        info_cnt_d        = in_info_rden ? wrap_inc(info_eff) : info_eff;
        in_info_rd_addr_d = info_eff;

        // Initialise write pipeline: aligns LLR writes with intrinsic RAM data.
        pipe_addr_d    = pipe_addr_q;
        pipe_vld_d     = pipe_vld_q;
        pipe_addr_d[0] = info_eff;
        pipe_vld_d[0]  = in_info_rden & initial_on;
        for (int i = 1; i < RW_DELAY; i++) begin
            pipe_addr_d[i] = pipe_addr_q[i-1];
            pipe_vld_d[i]  = pipe_vld_q[i-1];
        end
        drain_vld = pipe_vld_q[RW_DELAY-1];

        // Write side: CPU/VPU write-backs take precedence over draining entries.
        wr_strobe = vpu_wr_addr_en | cpu_wr_addr_en;
        wr_cnt_d  = wr_strobe ? wrap_inc(wr_eff) : wr_eff;
        wr_done_d = wr_strobe && (wr_eff == MAX_CNT);

        llr_wr_addr_d = llr_wr_addr_q;
        llr_wr_vld_d  = 1'b0;
        if (cpu_wr_addr_en) begin
            llr_wr_addr_d = mod_add(wr_eff, shift_eff);
            llr_wr_vld_d  = 1'b1;
        end else if (vpu_wr_addr_en) begin
            llr_wr_addr_d = wr_eff;
            llr_wr_vld_d  = 1'b1;
        end else if (drain_vld) begin
            llr_wr_addr_d = pipe_addr_q[RW_DELAY-1];
            llr_wr_vld_d  = 1'b1;
        end

        // Sticky protocol error
        collide     = wr_strobe & drain_vld;
        multi_on    = (initial_on & cpu_on) | (initial_on & vpu_on) | (cpu_on & vpu_on);
        phase_err_d = phase_err_q | collide | multi_on | shift_bad;
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            initial_on_q      <= 1'b0;
            cpu_on_q          <= 1'b0;
            vpu_on_q          <= 1'b0;
            shift_q           <= '0;
            rd_cnt_q          <= '0;
            wr_cnt_q          <= '0;
            info_cnt_q        <= '0;
            llr_rd_addr_q     <= '0;
            llr_wr_addr_q     <= '0;
            llr_wr_vld_q      <= 1'b0;
            in_info_rd_addr_q <= '0;
            rd_wrap_q         <= 1'b0;
            wr_done_q         <= 1'b0;
            phase_err_q       <= 1'b0;
            pipe_addr_q       <= '0;
            pipe_vld_q        <= '0;
        end else begin
            initial_on_q      <= initial_on;
            cpu_on_q          <= cpu_on;
            vpu_on_q          <= vpu_on;
            shift_q           <= shift_d;
            rd_cnt_q          <= rd_cnt_d;
            wr_cnt_q          <= wr_cnt_d;
            info_cnt_q        <= info_cnt_d;
            llr_rd_addr_q     <= llr_rd_addr_d;
            llr_wr_addr_q     <= llr_wr_addr_d;
            llr_wr_vld_q      <= llr_wr_vld_d;
            in_info_rd_addr_q <= in_info_rd_addr_d;
            rd_wrap_q         <= rd_wrap_d;
            wr_done_q         <= wr_done_d;
            phase_err_q       <= phase_err_d;
            pipe_addr_q       <= pipe_addr_d;
            pipe_vld_q        <= pipe_vld_d;
        end
    end

    assign llr_rd_addr     = llr_rd_addr_q;
    assign llr_wr_addr     = llr_wr_addr_q;
    assign llr_wr_vld      = llr_wr_vld_q;
    assign in_info_rd_addr = in_info_rd_addr_q;
    assign rd_wrap         = rd_wrap_q;
    assign wr_done         = wr_done_q;
    assign phase_err       = phase_err_q;

endmodule
`default_nettype wire

// File: tb/tb_llr_addr_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_llr_addr_gen
// Description : Directed self-checking bench for llr_addr_gen. Instance A uses
//               DEPTH=256; instance B uses DEPTH=200 for modulo arithmetic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_llr_addr_gen;

    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          initial_on, cpu_on, vpu_on;
    logic          llr_ram_rden, in_info_rden, vpu_wr_addr_en, cpu_wr_addr_en;
    logic [AW-1:0] shift_val;

    logic [AW-1:0] rd_addr_a, wr_addr_a, info_addr_a;
    logic          wr_vld_a, rd_wrap_a, wr_done_a, perr_a;
    logic [AW-1:0] rd_addr_b, wr_addr_b, info_addr_b;
    logic          wr_vld_b, rd_wrap_b, wr_done_b, perr_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    llr_addr_gen #(.ADDR_WIDTH(AW), .DEPTH(256), .RW_DELAY(2)) u_dut_a (
        .clk(clk), .rst_n(rst_n),
        .initial_on(initial_on), .cpu_on(cpu_on), .vpu_on(vpu_on),
        .llr_ram_rden(llr_ram_rden), .in_info_rden(in_info_rden),
        .vpu_wr_addr_en(vpu_wr_addr_en), .cpu_wr_addr_en(cpu_wr_addr_en),
        .shift_val(shift_val),
        .llr_rd_addr(rd_addr_a), .llr_wr_addr(wr_addr_a), .llr_wr_vld(wr_vld_a),
        .in_info_rd_addr(info_addr_a), .rd_wrap(rd_wrap_a), .wr_done(wr_done_a),
        .phase_err(perr_a)
    );

    llr_addr_gen #(.ADDR_WIDTH(AW), .DEPTH(200), .RW_DELAY(2)) u_dut_b (
        .clk(clk), .rst_n(rst_n),
        .initial_on(initial_on), .cpu_on(cpu_on), .vpu_on(vpu_on),
        .llr_ram_rden(llr_ram_rden), .in_info_rden(in_info_rden),
        .vpu_wr_addr_en(vpu_wr_addr_en), .cpu_wr_addr_en(cpu_wr_addr_en),
        .shift_val(shift_val),
        .llr_rd_addr(rd_addr_b), .llr_wr_addr(wr_addr_b), .llr_wr_vld(wr_vld_b),
        .in_info_rd_addr(info_addr_b), .rd_wrap(rd_wrap_b), .wr_done(wr_done_b),
        .phase_err(perr_b)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        initial_on = 0; cpu_on = 0; vpu_on = 0;
        llr_ram_rden = 0; in_info_rden = 0;
        vpu_wr_addr_en = 0; cpu_wr_addr_en = 0;
    endtask

    task automatic apply_reset();
        rst_n = 0;
        idle_inputs();
        repeat (2) tick();
        rst_n = 1;
    endtask

    initial begin
        int vld_cnt;
        int wrap_cnt;
        shift_val = '0;
        idle_inputs();
        rst_n = 0;
        @(negedge clk);
        apply_reset();

        // ---------------- reset state ----------------
        check_eq("rst rd_addr",   rd_addr_a,   0);
        check_eq("rst wr_addr",   wr_addr_a,   0);
        check_eq("rst wr_vld",    wr_vld_a,    0);
        check_eq("rst info_addr", info_addr_a, 0);
        check_eq("rst rd_wrap",   rd_wrap_a,   0);
        check_eq("rst wr_done",   wr_done_a,   0);
        check_eq("rst phase_err", perr_a,      0);

        // ---------------- CPU, shift 5, 264 reads + write burst ----------------
        cpu_on = 1; shift_val = 5; llr_ram_rden = 1; cpu_wr_addr_en = 1;
        wrap_cnt = 0;
        for (int k = 0; k < 264; k++) begin
            tick();
            check_eq($sformatf("cpu rd_addr k=%0d", k), rd_addr_a, (k + 5) % 256);
            check_eq($sformatf("cpu wr_addr k=%0d", k), wr_addr_a, (k + 5) % 256);
            check_eq($sformatf("cpu wr_vld k=%0d", k),  wr_vld_a,  1);
            check_eq($sformatf("cpu rd_wrap k=%0d", k), rd_wrap_a, (k == 255) ? 1 : 0);
            check_eq($sformatf("cpu wr_done k=%0d", k), wr_done_a, (k == 255) ? 1 : 0);
            if (rd_wrap_a) wrap_cnt++;
        end
        check_eq("cpu rd_wrap count", wrap_cnt, 1);
        idle_inputs();
        tick();
        check_eq("cpu idle wr_vld", wr_vld_a, 0);

        // ---------------- reset mid-CPU at rd_cnt=100 ----------------
        cpu_on = 1; shift_val = 5; llr_ram_rden = 1;
        repeat (100) tick();
        check_eq("mid cpu rd_addr", rd_addr_a, 104);
        check_eq("mid cpu wr_addr held", wr_addr_a, 12);
        rst_n = 0;
        idle_inputs();
        #1;
        check_eq("async rst rd_addr", rd_addr_a, 0);
        check_eq("async rst wr_addr", wr_addr_a, 0);
        repeat (2) tick();
        rst_n = 1;
        tick();
        cpu_on = 1; shift_val = 7; llr_ram_rden = 1;
        tick();
        check_eq("post rst cpu rd_addr0", rd_addr_a, 7);
        tick();
        check_eq("post rst cpu rd_addr1", rd_addr_a, 8);
        idle_inputs();
        tick();

        // ---------------- initialise phase, 256 info reads ----------------
        initial_on = 1; in_info_rden = 1;
        vld_cnt = 0;
        for (int k = 0; k < 260; k++) begin
            if (k == 256) idle_inputs();
            tick();
            if (k <= 255)
                check_eq($sformatf("init info_addr k=%0d", k), info_addr_a, k);
            check_eq($sformatf("init wr_vld k=%0d", k), wr_vld_a, (k >= 2 && k <= 257) ? 1 : 0);
            if (k >= 2 && k <= 257)
                check_eq($sformatf("init wr_addr k=%0d", k), wr_addr_a, k - 2);
            check_eq($sformatf("init wr_done k=%0d", k), wr_done_a, 0);
            if (wr_vld_a) vld_cnt++;
        end
        check_eq("init wr_vld count", vld_cnt, 256);

        // ---------------- VPU, 256 write strobes + reads ----------------
        vpu_on = 1; vpu_wr_addr_en = 1; llr_ram_rden = 1;
        for (int k = 0; k < 258; k++) begin
            if (k == 256) idle_inputs();
            tick();
            if (k <= 255) begin
                check_eq($sformatf("vpu wr_addr k=%0d", k), wr_addr_a, k);
                check_eq($sformatf("vpu rd_addr k=%0d", k), rd_addr_a, k);
            end
            check_eq($sformatf("vpu wr_vld k=%0d", k),  wr_vld_a,  (k <= 255) ? 1 : 0);
            check_eq($sformatf("vpu wr_done k=%0d", k), wr_done_a, (k == 255) ? 1 : 0);
        end
        check_eq("vpu phase_err clean", perr_a, 0);

        // ---------------- collision: VPU write vs draining init entry ----------------
        initial_on = 1; in_info_rden = 1;
        repeat (3) tick();                 // entries 0,1,2 enter the pipeline
        check_eq("coll drain0 wr_addr", wr_addr_a, 0);
        check_eq("coll drain0 perr", perr_a, 0);
        idle_inputs();
        vpu_on = 1; vpu_wr_addr_en = 1;
        tick();
        check_eq("coll vpu wins wr_addr", wr_addr_a, 0);
        check_eq("coll vpu wins wr_vld", wr_vld_a, 1);
        check_eq("coll phase_err", perr_a, 1);
        vpu_wr_addr_en = 0;
        tick();
        check_eq("coll drain2 wr_addr", wr_addr_a, 2);
        check_eq("coll drain2 wr_vld", wr_vld_a, 1);
        apply_reset();
        check_eq("coll perr cleared", perr_a, 0);

        // ---------------- simultaneous phases ----------------
        cpu_on = 1; vpu_on = 1;
        tick();
        check_eq("multi phase_err", perr_a, 1);
        idle_inputs();
        repeat (5) tick();
        check_eq("multi phase_err sticky", perr_a, 1);
        rst_n = 0;
        #1;
        check_eq("multi phase_err reset", perr_a, 0);
        @(negedge clk);
        apply_reset();

        // ---------------- DEPTH=200 modulo ----------------
        cpu_on = 1; shift_val = 150; llr_ram_rden = 1;
        for (int k = 0; k <= 60; k++) begin
            tick();
            check_eq($sformatf("d200 rd_addr k=%0d", k), rd_addr_b, (k + 150) % 200);
        end
        check_eq("d200 rd_addr at cnt60", rd_addr_b, 10);
        check_eq("d200 phase_err clean", perr_b, 0);
        idle_inputs();
        tick();
        cpu_on = 1; shift_val = 210;
        tick();
        check_eq("d200 bad shift rd_addr", rd_addr_b, 0);
        check_eq("d200 bad shift perr", perr_b, 1);
        check_eq("d256 shift210 rd_addr", rd_addr_a, 210);
        check_eq("d256 shift210 perr", perr_a, 0);
        idle_inputs();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
